// File: rtl/cla_pkg.sv
// Shared definitions for the CLA block accumulator: data width, saturation limits, FSM states.
package cla_pkg;

    localparam int DATA_W = 8;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 8'sd127;
    localparam logic signed [DATA_W-1:0] SAT_MIN = -8'sd128;

    typedef enum logic {
        S_ACC,
        S_OUT
    } acc_state_t;

endpackage

// File: rtl/cla_8bit_ovf_uvf.sv
// 8-bit carry-lookahead adder with signed overflow (pos+pos->neg) and underflow (neg+neg->non-neg) flags.
module cla_8bit_ovf_uvf
    import cla_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              ovf,
    output logic              uvf
);

    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W:0]   c;
    logic              term;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded as an OR of generate terms gated by all intervening propagates.
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign sum = p ^ c[DATA_W-1:0];
    assign ovf = ~a[DATA_W-1] & ~b[DATA_W-1] &  sum[DATA_W-1];
    assign uvf =  a[DATA_W-1] &  b[DATA_W-1] & ~sum[DATA_W-1];

endmodule

// File: rtl/cla_sat_accumulator.sv
// Sums BLOCK_LEN signed samples through the CLA and presents the result on a valid/ready port.
// Define CLA_ACC_SAT_EN to clamp the accumulator on overflow/underflow instead of wrapping.
module cla_sat_accumulator
    import cla_pkg::*;
#(
    parameter int unsigned BLOCK_LEN = 4,
    parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic              out_uvf,
    output logic [CNT_W-1:0]  out_evt
);

    acc_state_t        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_st_q, ovf_st_d;
    logic              uvf_st_q, uvf_st_d;
    logic [CNT_W-1:0]  evt_q, evt_d;
    logic [DATA_W-1:0] res_sum_q, res_sum_d;
    logic              res_ovf_q, res_ovf_d;
    logic              res_uvf_q, res_uvf_d;
    logic [CNT_W-1:0]  res_evt_q, res_evt_d;

    logic [DATA_W-1:0] cla_sum;
    logic              cla_ovf;
    logic              cla_uvf;
    logic [DATA_W-1:0] next_acc;

    cla_8bit_ovf_uvf u_cla (
        .a   (acc_q),
        .b   (in_data),
        .sum (cla_sum),
        .ovf (cla_ovf),
        .uvf (cla_uvf)
    );

`ifdef CLA_ACC_SAT_EN
    assign next_acc = cla_ovf ? SAT_MAX : (cla_uvf ? SAT_MIN : cla_sum);
`else
    assign next_acc = cla_sum;
`endif

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign out_sum   = res_sum_q;
    assign out_ovf   = res_ovf_q;
    assign out_uvf   = res_uvf_q;
    assign out_evt   = res_evt_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_st_d  = ovf_st_q;
        uvf_st_d  = uvf_st_q;
        evt_d     = evt_q;
        res_sum_d = res_sum_q;
        res_ovf_d = res_ovf_q;
        res_uvf_d = res_uvf_q;
        res_evt_d = res_evt_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    acc_d    = next_acc;
                    ovf_st_d = ovf_st_q | cla_ovf;
                    uvf_st_d = uvf_st_q | cla_uvf;
                    evt_d    = evt_q + CNT_W'(cla_ovf | cla_uvf);
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
                        res_sum_d = next_acc;
                        res_ovf_d = ovf_st_d;
                        res_uvf_d = uvf_st_d;
                        res_evt_d = evt_d;
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_st_d = 1'b0;
                    uvf_st_d = 1'b0;
                    evt_d    = '0;
                    state_d  = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_st_q  <= 1'b0;
            uvf_st_q  <= 1'b0;
            evt_q     <= '0;
            res_sum_q <= '0;
            res_ovf_q <= 1'b0;
            res_uvf_q <= 1'b0;
            res_evt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_st_q  <= ovf_st_d;
            uvf_st_q  <= uvf_st_d;
            evt_q     <= evt_d;
            res_sum_q <= res_sum_d;
            res_ovf_q <= res_ovf_d;
            res_uvf_q <= res_uvf_d;
            res_evt_q <= res_evt_d;
        end
    end

endmodule

// File: tb/tb_cla_sat_accumulator.sv
// Randomized and directed bench for cla_sat_accumulator against an integer-arithmetic block model.
module tb_cla_sat_accumulator;

    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       out_uvf;
    logic [2:0] out_evt;

    int vectors = 0;
    int miscompares = 0;

    cla_sat_accumulator #(.BLOCK_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_uvf   (out_uvf),
        .out_evt   (out_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer sums, range tests for flags.
    bit m_busy;
    int m_acc, m_cnt, m_evt;
    bit m_ovf, m_uvf;
    int r_sum, r_evt;
    bit r_ovf, r_uvf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_acc = 0; m_cnt = 0; m_evt = 0; m_ovf = 0; m_uvf = 0;
            r_sum = 0; r_evt = 0; r_ovf = 0; r_uvf = 0;
        end else if (!m_busy && in_valid) begin
            int s;
            bit o, u;
            s = m_acc + int'($signed(in_data));
            o = (s > 127);
            u = (s < -128);
`ifdef CLA_ACC_SAT_EN
            m_acc = o ? 127 : (u ? -128 : s);
`else
            m_acc = ((s + 128) & 255) - 128;
`endif
            m_ovf = m_ovf | o;
            m_uvf = m_uvf | u;
            m_evt = m_evt + ((o || u) ? 1 : 0);
            m_cnt = m_cnt + 1;
            if (m_cnt == BL) begin
                m_busy = 1;
                r_sum = m_acc; r_ovf = m_ovf; r_uvf = m_uvf; r_evt = m_evt;
            end
        end else if (m_busy && out_ready) begin
            m_busy = 0; m_acc = 0; m_cnt = 0; m_evt = 0; m_ovf = 0; m_uvf = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sum", $signed(out_sum), 0);
            chk("rst_out_ovf", out_ovf, 0);
            chk("rst_out_uvf", out_uvf, 0);
            chk("rst_out_evt", out_evt, 0);
        end else begin
            chk("in_ready", in_ready, !m_busy);
            chk("out_valid", out_valid, m_busy);
            if (m_busy) begin
                chk("out_sum", $signed(out_sum), r_sum);
                chk("out_ovf", out_ovf, r_ovf);
                chk("out_uvf", out_uvf, r_uvf);
                chk("out_evt", out_evt, r_evt);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int x);
        int budget;
        budget = 0;
        in_valid = 1'b1;
        in_data  = 8'(x);
        while (!in_ready && budget < 50) begin
            step();
            budget++;
        end
        if (budget >= 50) chk("send_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_blk(input string name, input int s0, input int s1, input int s2, input int s3,
                           input int e_sum, input int e_ovf, input int e_uvf, input int e_evt);
        out_ready = 1'b1;
        send(s0); send(s1); send(s2); send(s3);
        chk({name, "_latency"}, out_valid, 1);
        chk({name, "_sum"}, $signed(out_sum), e_sum);
        chk({name, "_ovf"}, out_ovf, e_ovf);
        chk({name, "_uvf"}, out_uvf, e_uvf);
        chk({name, "_evt"}, out_evt, e_evt);
        step();
        chk({name, "_drop"}, out_valid, 0);
    endtask

    initial begin
        step();
        step();
        chk("reset_ready", in_ready, 1);
        chk("reset_sum", $signed(out_sum), 0);
        rst = 1'b0;
        step();

        run_blk("noflag", 10, 20, 30, 40, 100, 0, 0, 0);
`ifdef CLA_ACC_SAT_EN
        run_blk("ovfsat", 127, 1, 0, 0, 127, 1, 0, 1);
        run_blk("satwrap", 100, 100, -100, -100, -73, 1, 0, 1);
        run_blk("uvfsat", -128, -1, -1, 5, -123, 0, 1, 2);
`else
        run_blk("ovfsat", 127, 1, 0, 0, -128, 1, 0, 1);
        run_blk("satwrap", 100, 100, -100, -100, 0, 1, 1, 2);
        run_blk("uvfsat", -128, -1, -1, 5, -125, 1, 1, 2);
`endif

        // Backpressure with a sample waiting during S_OUT.
        out_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", $signed(out_sum), 10);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_after_hs_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        send(1); send(1); send(1);
        chk("bp_next_sum", $signed(out_sum), 10);
        chk("bp_next_valid", out_valid, 1);
        step();

        // Reset in the middle of a block.
        send(50); send(50);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();
        run_blk("afterrst", 1, 1, 1, 1, 4, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int pick;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: in_data = 8'h7f;
                1: in_data = 8'h80;
                2: in_data = 8'hff;
                default: in_data = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cla_sat_accumulator.md
# cla_sat_accumulator

Sequential block-accumulator that sits directly downstream of the 8-bit CLA with overflow/underflow detection. It consumes a stream of signed 8-bit samples and sums BLOCK_LEN of them, using the CLA for every addition. It then presents the block result on a valid/ready output together with sticky overflow/underflow flags and a count of flagged additions. It turns the combinational adder into the first clocked stage of the datapath.

## Interface
- BLOCK_LEN, 4: samples summed per result; legal range 1..255.
- CNT_W, $clog2(BLOCK_LEN+1): width of the sample counter and the event counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  8  signed two's-complement sample.
- out_valid  out  1  block result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  8  signed block sum.
- out_ovf  out  1  sticky: at least one addition in the block overflowed (positive).
- out_uvf  out  1  sticky: at least one addition in the block underflowed (negative).
- out_evt  out  CNT_W  number of additions in the block that raised ovf or uvf.

## Operation
- States: S_ACC and S_OUT. The reset state is S_ACC.
- S_ACC:
  - in_ready=1, out_valid=0.
  - A sample is accepted when in_valid && in_ready.
  - On acceptance, the CLA computes acc + in_data.
  - acc <= next_acc.
  - ovf_st |= ovf and uvf_st |= uvf.
  - evt increments if (ovf|uvf).
  - cnt increments.
- Last sample (cnt==BLOCK_LEN-1 at acceptance):
  - out_sum, out_ovf, out_uvf and out_evt load the post-update values.
  - The state moves to S_OUT.
- S_OUT:
  - in_ready=0, out_valid=1.
  - Outputs are held stable until out_ready.
  - On out_valid && out_ready: acc, cnt, ovf_st, uvf_st and evt clear to 0; the state moves to S_ACC.
- Arithmetic:
  - The accumulator is 8-bit signed.
  - ovf/uvf come from the CLA (sign rules: two positive operands giving a negative result set ovf; two negative operands giving a non-negative result set uvf).
  - ovf and uvf are never both set for one addition.
- Saturated accumulator: the next addition uses the saturated value.
- BLOCK_LEN=1: every accepted sample produces a result, i.e. 0 + sample.
- out_evt never exceeds BLOCK_LEN, so it cannot wrap.

## Timing
- Reset values:
  - in_ready=1 (asserted as reset releases).
  - out_valid=0, out_sum=0, out_ovf=0, out_uvf=0, out_evt=0.
  - acc=0, cnt=0, state=S_ACC.
- Latency: out_valid rises the cycle after the edge that accepted the last sample.
- Minimum period: BLOCK_LEN+1 cycles per block, because S_OUT lasts at least one cycle.
- in_ready is a function of state only; there is no combinational path from out_ready to in_ready.
- Reset mid-block or mid-S_OUT: the partial block is discarded, out_valid drops immediately, and counting restarts from 0.
- in_valid asserted during S_OUT: the sample is not accepted. The producer must hold it.

## Configuration
- CLA_ACC_SAT_EN defined: on the CLA's ovf, next_acc=+127; on uvf, next_acc=-128; otherwise next_acc is the CLA sum.
- CLA_ACC_SAT_EN undefined: next_acc is always the CLA sum (two's-complement wrap).
- In both cases the flags and out_evt behave identically.

## Structure
- Package cla_pkg holds:
  - DATA_W=8.
  - SAT_MAX=8'sd127 and SAT_MIN=-8'sd128.
  - The state enum typedef acc_state_t {S_ACC, S_OUT}.
- One sub-module: an instance of cla_8bit_ovf_uvf, with a=acc, b=in_data, and sum/ovf/uvf feeding the next-state logic.
- No other hierarchy.

## Test plan
All scenarios use BLOCK_LEN=4.
- No flags: samples 10,20,30,40 with out_ready=1 -> out_sum=100, ovf=0, uvf=0, evt=0; out_valid rises exactly one cycle after the 4th acceptance.
- Overflow saturation: 127,1,0,0 -> with CLA_ACC_SAT_EN, out_sum=127, ovf=1, evt=1; without it, out_sum=-128, ovf=1, evt=1.
- Saturation vs wrap: 100,100,-100,-100 -> SAT gives 100, 127(ovf), 27, -73, so out_sum=-73, ovf=1, uvf=0, evt=1; no-SAT gives 100, -56(ovf), 100(uvf), 0, so out_sum=0, ovf=1, uvf=1, evt=2.
- Underflow saturation (SAT build): -128,-1,-1,5 -> out_sum=-123, uvf=1, ovf=0, evt=2.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid held high -> in_ready=0 and outputs unchanged throughout. The first sample of the next block is accepted the cycle after the handshake.
- Reset mid-block: assert rst after 2 samples (50,50) -> all outputs return to reset values. The next samples 1,1,1,1 give out_sum=4, evt=0.
